shift_pipe: RTL
===============

# shift_pipe

Pipelined, parametrised shift/rotate execution unit for the NPC integer datapath, the elastic successor to the single-cycle `Shift` block. It accepts one operation per cycle through a valid/ready handshake and spreads the log2(WIDTH) barrel-shift layers over a configurable number of register stages. It adds rotate ops (Zbb ROL/ROR), RV64 word variants (SLLW/SRLW/SRAW/ROLW/RORW) and a tag field, and sits between issue and writeback with a flush input for mispredicts.

## Interface
- `WIDTH`, 32: datapath width; 32 or 64.
- `STAGES`, 2: register stages, 1..$clog2(WIDTH); equals latency.
- `TAG_W`, 5: width of the passthrough tag (rd index).
- `HAS_WORD`, 0: 1 enables word mode; legal only with WIDTH=64.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill all in-flight ops this edge.
- `in_valid`  in  1  op offered.
- `in_ready`  out  1  unit accepts op this cycle.
- `in_data`  in  WIDTH  operand to shift (old `inw`).
- `in_shamt`  in  WIDTH  shift amount; only low $clog2(WIDTH) bits used (low 5 in word mode).
- `in_op`  in  3  operation, see Operation.
- `in_word`  in  1  word-mode op; ignored when HAS_WORD=0.
- `in_tag`  in  TAG_W  passthrough tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  WIDTH  result.
- `out_tag`  out  TAG_W  tag of the result.

## Operation
- Ops: 0 SLL, 1 SRL (zero fill), 2 SRA (sign fill), 3 ROL, 4 ROR; 5–7 reserved → out_data = 0, still handshaked, tag passed.
- Shift count: full-width mode uses `in_shamt[$clog2(WIDTH)-1:0]`; larger values wrap, never saturate.
- Word mode (HAS_WORD=1, in_word=1): operand = `in_data[31:0]`, shamt = `in_shamt[4:0]`, SRA fills from bit 31, rotates wrap within 32 bits; 32-bit result sign-extended from bit 31 to 64.
- shamt = 0 → out_data = operand (sign-extended in word mode) for every legal op.
- Barrel layers k = 0..L-1 (L = $clog2(WIDTH)); layer k shifts by 2^k when shamt bit k is set. Stage s (0..STAGES-1) holds layers floor(s·L/STAGES) .. floor((s+1)·L/STAGES)-1; op, word, fill bit, remaining shamt and tag ride with the data.
- Pipeline advance: `adv = !out_valid | out_ready`; all stages shift together on `adv`; bubbles are not compressed.
- `in_ready = adv & !flush`. Transfer occurs when `in_valid & in_ready`.
- Flush: at the edge with flush=1, every stage valid bit clears; no op offered that cycle is accepted. Data/tag registers may keep stale values.
- Reset: all stage valid bits 0, out_valid 0, out_data 0, out_tag 0; reset overrides flush and in_valid.

## Timing
- Latency: op accepted at edge n appears with out_valid=1 after edge n+STAGES (given no stall).
- Throughput: one op per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 → out_data, out_tag, out_valid held stable; in_ready=0 same cycle (combinational from out_ready).
- out_valid, out_data, out_tag are register outputs; no combinational path from in_* to out_*.
- in_ready depends combinationally only on out_valid, out_ready, flush.
- Simultaneous out handshake and new input in a full pipe: both complete at the same edge.

## Structure
- Package `shift_pkg`: enum `shift_op_e` (SLL, SRL, SRA, ROL, ROR), op width constant 3, helper function for the layer-range of stage s.
- Sub-module `shift_stage`: one register stage applying a parameterised contiguous range of barrel layers with valid/enable; `shift_pipe` instantiates STAGES copies in a generate loop and owns handshake, flush and word-mode pre/post processing (sign-extension).

## Test plan
- WIDTH=32, STAGES=2: SRA `in_data=0x8000_0000`, shamt=4 → out_data 0xF800_0000 exactly 2 cycles later; SRL same → 0x0800_0000; ROR 0x0000_0001 by 1 → 0x8000_0000.
- Wrap: shamt=0x0000_0021, SLL 0x1 → 0x0000_0002; shamt=0 ROL 0xDEAD_BEEF → 0xDEAD_BEEF; op=6 → 0 with tag preserved.
- WIDTH=64, HAS_WORD=1: SRLW 0xFFFF_FFFF_8000_0000 by 0 → 0xFFFF_FFFF_8000_0000; SLLW 0x1 by 31 → 0xFFFF_FFFF_8000_0000; SRAW 0x0000_0000_8000_0000 by 36 (→4) → 0xFFFF_FFFF_F800_0000.
- Back-pressure: 4 back-to-back ops, out_ready low for 3 cycles after first result → results held stable, in_ready low, all 4 emerge in order with correct tags, no loss/duplication.
- Flush with 2 ops in flight plus in_valid=1 → none of the 3 ever appear; op issued next cycle appears after STAGES cycles.
- Reset asserted mid-stream with out_valid=1 → next cycle out_valid=0, out_data=0, out_tag=0; random stream vs reference model for STAGES=1..5 at WIDTH=32.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the pipelined shift/rotate unit.
// Stage boundaries are computed here so the top and the stages agree on layer ownership.
package shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // First barrel layer owned by stage s; stage s covers layer_lo(s) .. layer_lo(s+1)-1.
    function automatic int layer_lo(input int s, input int layers, input int stages);
        return (s * layers) / stages;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One register stage of the shift pipeline: applies barrel layers LO..HI-1 and
// registers the result together with the control fields that ride alongside it.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int LO    = 0,
    parameter int HI    = 1,
    parameter bit FINAL = 1'b0,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_word,
    input  logic             in_fill,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OP_W-1:0]  out_op,
    output logic             out_word,
    output logic             out_fill,
    output logic [SHW-1:0]   out_shamt,
    output logic [TAG_W-1:0] out_tag
);

    function automatic logic [WIDTH-1:0] apply_layer(
        input logic [WIDTH-1:0] d,
        input logic [OP_W-1:0]  op,
        input logic             word,
        input logic             fill,
        input int               k
    );
        int               amt;
        logic [31:0]      lo;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        amt  = 1 << k;
        lo   = d[31:0];
        ones = '1;
        r    = d;
        case (shift_op_e'(op))
            OP_SLL: r = d << amt;
            OP_SRL, OP_SRA: r = (d >> amt) | (fill ? ~(ones >> amt) : '0);
            // Word rotates wrap inside the low 32 bits; upper bits are rebuilt at the end.
            OP_ROL: begin
                if (word) begin
                    r = '0;
                    r[31:0] = (lo << amt) | (lo >> (32 - amt));
                end else begin
                    r = (d << amt) | (d >> (WIDTH - amt));
                end
            end
            OP_ROR: begin
                if (word) begin
                    r = '0;
                    r[31:0] = (lo >> amt) | (lo << (32 - amt));
                end else begin
                    r = (d >> amt) | (d << (WIDTH - amt));
                end
            end
            default: r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        for (int k = LO; k < HI; k++) begin
            if (in_shamt[k]) begin
                shifted = apply_layer(shifted, in_op, in_word, in_fill, k);
            end
        end
        if (FINAL && in_word) begin
            for (int i = 32; i < WIDTH; i++) begin
                shifted[i] = shifted[31];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= '0;
            out_word  <= 1'b0;
            out_fill  <= 1'b0;
            out_shamt <= '0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= in_valid;
            end
            if (en) begin
                out_data  <= shifted;
                out_op    <= in_op;
                out_word  <= in_word;
                out_fill  <= in_fill;
                out_shamt <= in_shamt;
                out_tag   <= in_tag;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Elastic pipelined shift/rotate unit: SLL/SRL/SRA/ROL/ROR with optional RV64 word forms,
// barrel layers spread over STAGES register stages, valid/ready in and out, flush for mispredicts.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter int TAG_W    = 5,
    parameter bit HAS_WORD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: a transfer happens on an edge where valid & ready are both high.
    // The whole pipe advances when the output slot is empty or being taken (no bubble
    // compression); in_ready is that advance term masked by flush and never looks at in_valid.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !flush;

    logic             sv     [STAGES+1];
    logic [WIDTH-1:0] sd     [STAGES+1];
    logic [OP_W-1:0]  sop    [STAGES+1];
    logic             sword  [STAGES+1];
    logic             sfill  [STAGES+1];
    logic [SHW-1:0]   sshamt [STAGES+1];
    logic [TAG_W-1:0] stag   [STAGES+1];

    logic is_word;
    logic is_sra;
    logic is_legal;

    always_comb begin
        is_word  = HAS_WORD && in_word;
        is_sra   = (in_op == OP_SRA);
        is_legal = (in_op <= OP_ROR);

        sv[0]     = in_valid && in_ready;
        sop[0]    = in_op;
        sword[0]  = is_word;
        stag[0]   = in_tag;
        sd[0]     = in_data;
        sshamt[0] = in_shamt[SHW-1:0];
        sfill[0]  = is_sra && (is_word ? in_data[31] : in_data[WIDTH-1]);

        // Word ops see a 32-bit operand whose upper half already holds the right-shift fill.
        if (is_word) begin
            for (int i = 32; i < WIDTH; i++) begin
                sd[0][i] = is_sra && in_data[31];
            end
            for (int i = 5; i < SHW; i++) begin
                sshamt[0][i] = 1'b0;
            end
        end

        if (!is_legal) begin
            sd[0]    = '0;
            sfill[0] = 1'b0;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LO    (layer_lo(s, SHW, STAGES)),
            .HI    (layer_lo(s + 1, SHW, STAGES)),
            .FINAL (s == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .en        (adv),
            .in_valid  (sv[s]),
            .in_data   (sd[s]),
            .in_op     (sop[s]),
            .in_word   (sword[s]),
            .in_fill   (sfill[s]),
            .in_shamt  (sshamt[s]),
            .in_tag    (stag[s]),
            .out_valid (sv[s+1]),
            .out_data  (sd[s+1]),
            .out_op    (sop[s+1]),
            .out_word  (sword[s+1]),
            .out_fill  (sfill[s+1]),
            .out_shamt (sshamt[s+1]),
            .out_tag   (stag[s+1])
        );
    end

    assign out_valid = sv[STAGES];
    assign out_data  = sd[STAGES];
    assign out_tag   = stag[STAGES];

    // Control fields leaving the last stage and the ignored high shamt bits have no consumer.
    logic unused_bits;
    assign unused_bits = ^{in_shamt[WIDTH-1:SHW], sop[STAGES], sword[STAGES],
                           sfill[STAGES], sshamt[STAGES]};

endmodule
